ao311_unit: RTL and testbench
=============================

# ao311_unit

Registered AND-OR-311 function unit with built-in dual-implementation self-check. It computes z = (a & b & c) | d | e in two ways: a behavioral sum-of-products form and a structural NAND-only form derived by De Morgan. Both results are registered. The block flags any disagreement between them and tracks which of the 32 input patterns have been applied. It sits as a leaf logic cell in the datapath and doubles as a gate-level equivalence monitor during bring-up.

## Interface
Parameters:
- ERR_W, default 8: width of the mismatch error counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; inputs are captured only when high.
- a, b, c  in  1 each  three-input AND term operands.
- d, e  in  1 each  single-literal OR terms.
- z  out  1  registered structural (NAND-only) result.
- z_rtl  out  1  registered behavioral result.
- mismatch  out  1  sticky flag; set when z differs from z_rtl.
- err_cnt  out  ERR_W  saturating count of mismatching samples.
- cov  out  32  coverage vector; bit {a,b,c,d,e} is set once that pattern has been sampled.
- cov_full  out  1  high when cov equals all ones.

## Operation
- Behavioral path: z_rtl_n = (a & b & c) | d | e.
- Structural path uses only 2-, 3- and 4-input NAND primitives:
  - n1 = NAND(a,b,c)
  - nd = NAND(d,d)
  - ne = NAND(e,e)
  - z_n = NAND(n1, nd, ne)
- Structural inverters are NAND gates with tied inputs. No AND, OR or NOT operators are allowed in this path.
- On a clock edge with en=1:
  - z is loaded with z_n and z_rtl is loaded with z_rtl_n.
  - cov[{a,b,c,d,e}] is set to 1. The index is a 5-bit value with a as the MSB.
- Comparison is done on the registered outputs. In every cycle where z !== z_rtl (X or Z counts as a mismatch):
  - mismatch is set to 1.
  - err_cnt increments by 1, saturating at 2^ERR_W-1.
- With en=0, all registers hold their values.
- mismatch, err_cnt and cov are cleared only by rst.
- cov_full is combinational from cov.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on z and z_rtl after edge N.
- mismatch and err_cnt update one cycle after the differing z/z_rtl values appear, so they lag the inputs by 2 cycles.
- Synchronous reset, taking effect at the next rising edge, forces:
  - z=0, z_rtl=0, mismatch=0, err_cnt=0, cov=0, which makes cov_full=0.
- rst has priority over en.
- Reset asserted mid-sequence discards any comparison in flight; no error is counted for the reset cycle.
- An input change while en=0 has no effect.
- err_cnt at its maximum value stays at the maximum.

## Configuration
- AO311_SELFCHECK_EN defined:
  - Both paths, the comparator, mismatch and err_cnt are built.
- AO311_SELFCHECK_EN undefined:
  - Only the structural path is built.
  - z_rtl is driven from the same register as z.
  - mismatch and err_cnt are tied to 0.
  - cov and cov_full remain functional.

## Test plan
- Reset: assert rst for 2 cycles with en=1 and abcde=11111 -> z=0, z_rtl=0, mismatch=0, err_cnt=0, cov=0 after the edge.
- Exhaustive sweep: en=1, drive abcde = 0..31 with one value per cycle, a as MSB. Required results:
  - z=1 exactly for patterns with d|e=1, plus 11100.
  - z=0 for 00000, 11000, 10100, 01100.
  - The count of z=1 cycles is 25.
  - z equals z_rtl in every cycle.
  - cov_full=1 after the last edge.
  - mismatch=0 and err_cnt=0 throughout.
- Hold: sample 11100 (z=1), then set en=0 and drive 00000 for 3 cycles -> z stays 1 and cov has only bit 28 set.
- Fault injection: force the structural z_n to 0 with abcde=00001 for 3 enabled cycles:
  - mismatch=1 two cycles after the first sample.
  - err_cnt=3 after the comparisons complete.
  - After release and further clean samples, mismatch stays 1.
- Saturation: with ERR_W=2, inject 5 consecutive mismatches -> err_cnt=3.
- Reset mid-run: apply rst after half the sweep -> cov=0, and cov_full is reached only after all 32 patterns are reapplied.

Source files
------------

// File: rtl/ao311_unit.sv
// ao311_unit: registered AND-OR-311 (z = a&b&c | d | e) with NAND-only structural path, pattern coverage,
// and an optional behavioral-vs-structural checker built when AO311_SELFCHECK_EN is defined.
module ao311_unit #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             z,
  output logic             z_rtl,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      cov,
  output logic             cov_full
);
  logic       n1, nd, ne, z_n;
  logic [4:0] idx;
  // NAND-only network; single-literal inverters are NANDs with tied inputs
  assign n1       = ~&{a, b, c};
  assign nd       = ~&{d, d};
  assign ne       = ~&{e, e};
  assign z_n      = ~&{n1, nd, ne};
  assign idx      = {a, b, c, d, e};
  assign cov_full = &cov;
  always_ff @(posedge clk)
    if (rst) begin
      z   <= 1'b0;
      cov <= '0;
    end else if (en) begin
      z        <= z_n;
      cov[idx] <= 1'b1;
    end
`ifdef AO311_SELFCHECK_EN
  logic z_rtl_n, vld;
  assign z_rtl_n = (a & b & c) | d | e;
  // vld marks that the registered pair holds a fresh sample, so each sample is compared exactly once
  always_ff @(posedge clk)
    if (rst) begin
      z_rtl    <= 1'b0;
      vld      <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      vld <= en;
      if (en) z_rtl <= z_rtl_n;
      if (vld && (z !== z_rtl)) begin
        mismatch <= 1'b1;
        if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
      end
    end
`else
  assign z_rtl    = z;
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_ao311_unit.sv
// tb_ao311_unit: scoreboard bench; stimulus pushes expected post-edge state, a monitor pops and compares each cycle.
module tb_ao311_unit;
  logic clk = 0, rst = 0, en = 0, a = 0, b = 0, c = 0, d = 0, e = 0;
  logic z, z_rtl, mismatch, cov_full;
  logic [7:0] err_cnt;
  logic [31:0] cov;
  int total = 0, bad = 0, ones = 0;
  always #5 clk = ~clk;
  ao311_unit dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e),
    .z(z), .z_rtl(z_rtl), .mismatch(mismatch), .err_cnt(err_cnt), .cov(cov), .cov_full(cov_full)
  );
`ifdef AO311_SELFCHECK_EN
  logic z2, zr2, mis2, cf2;
  logic [1:0] err2;
  logic [31:0] cov2;
  ao311_unit #(.ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e),
    .z(z2), .z_rtl(zr2), .mismatch(mis2), .err_cnt(err2), .cov(cov2), .cov_full(cf2)
  );
`endif
  typedef struct packed {
    logic z, zr, mis;
    logic [7:0] err;
    logic [31:0] cov;
    logic cnt;
  } exp_t;
  exp_t q[$];
  // hand-derived truth table of z per pattern {a,b,c,d,e}: d|e, plus 11100
  logic [31:0] ztab = 32'hFEEE_EEEE;
  logic mz = 0, mzr = 0, mmis = 0, mvld = 0;
  logic [7:0] merr = 0;
  logic [31:0] mcov = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic ee, input logic [4:0] p, input logic cnt, input logic [1:0] f);
    @(negedge clk);
`ifdef AO311_SELFCHECK_EN
    if (f[0]) force dut.z_n = 1'b0; else release dut.z_n;
    if (f[1]) force u2.z_n = 1'b0; else release u2.z_n;
`endif
    rst = r; en = ee; {a, b, c, d, e} = p;
    if (r) begin
      mz = 0; mzr = 0; mmis = 0; mvld = 0; merr = 0; mcov = 0;
    end else begin
`ifdef AO311_SELFCHECK_EN
      if (mvld && mz !== mzr) begin
        mmis = 1;
        if (merr != 8'hFF) merr = merr + 1;
      end
`endif
      mvld = ee;
      if (ee) begin
        mzr = ztab[p];
        mz = f[0] ? 1'b0 : ztab[p];
        mcov[p] = 1'b1;
      end
    end
`ifndef AO311_SELFCHECK_EN
    mzr = mz;
`endif
    q.push_back('{z: mz, zr: mzr, mis: mmis, err: merr, cov: mcov, cnt: cnt});
  endtask
  initial forever begin
    exp_t x;
    @(posedge clk); #2;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk("z", {31'b0, z}, {31'b0, x.z});
      chk("z_rtl", {31'b0, z_rtl}, {31'b0, x.zr});
      chk("mismatch", {31'b0, mismatch}, {31'b0, x.mis});
      chk("err_cnt", {24'b0, err_cnt}, {24'b0, x.err});
      chk("cov", cov, x.cov);
      chk("cov_full", {31'b0, cov_full}, {31'b0, &x.cov});
      if (x.cnt && z === 1'b1) ones++;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end, bad=%0d", bad);
    $fatal(1);
  end
  initial begin
    cyc(1, 1, 5'd31, 0, 0);
    cyc(1, 1, 5'd31, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ones_count", ones, 25);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 5'b11100, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 5'b00000, 0, 0);
`ifdef AO311_SELFCHECK_EN
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'b00001, 0, 2'b01);
    cyc(0, 1, 5'b10000, 0, 0);
    cyc(0, 1, 5'b00010, 0, 0);
    cyc(0, 1, 5'b11100, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 5'b00001, 0, 2'b10);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_err_cnt", {30'b0, err2}, 32'd3);
    chk("sat_mismatch", {31'b0, mis2}, 32'd1);
    cyc(0, 0, 0, 0, 0);
`endif
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 5'(i), 0, 0);
    cyc(1, 1, 5'd31, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 5'(31 - i), 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
